// File: rtl/pulse_transmitter_multi_timer.sv
// Bank of independent programmable timers; each emits a registered one-cycle pulse
// D+1 edges after start, where D = duration << clamp(prescaler). No backpressure.
module pulse_transmitter_multi_timer #(
  parameter int NUM_CH          = 4,
  parameter int PRESCALER_WIDTH = 15,
  parameter int TIMER_WIDTH     = 8,
  localparam int PW             = $clog2(PRESCALER_WIDTH + 1),
  localparam int CW             = PRESCALER_WIDTH + TIMER_WIDTH
) (
  input  logic                          clk,
  input  logic                          sys_rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             oneshot,
  input  logic [NUM_CH*PW-1:0]          prescaler,
  input  logic [NUM_CH*TIMER_WIDTH-1:0] duration,
  output logic [NUM_CH-1:0]             pulse_out,
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             done,
  output logic                          pulse_any
);

  localparam logic [PW-1:0] PMAX = PW'(PRESCALER_WIDTH);

  logic [CW-1:0]     counter [NUM_CH];
  logic [CW-1:0]     load    [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] expire;

  // Shift is applied at full counter width so the largest duration never truncates.
  function automatic logic [CW-1:0] load_val(input logic [TIMER_WIDTH-1:0] dur,
                                             input logic [PW-1:0]          pre);
    logic [PW-1:0] sh;
    sh = (pre > PMAX) ? PMAX : pre;
    return CW'(dur) << sh;
  endfunction

  always_comb begin
    start  = '0;
    expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i]   = load_val(duration[i*TIMER_WIDTH +: TIMER_WIDTH], prescaler[i*PW +: PW]);
      start[i]  = en[i] && !en_q[i];
      expire[i] = en[i] && en_q[i] && busy[i] && (counter[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_CH; i++) counter[i] <= '0;
      busy      <= '0;
      done      <= '0;
      en_q      <= '0;
      pulse_out <= '0;
      pulse_any <= 1'b0;
    end else begin
      en_q      <= en;
      pulse_out <= expire;
      pulse_any <= |expire;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en[i]) begin
          busy[i]    <= 1'b0;
          counter[i] <= '0;
        end else if (start[i]) begin
          counter[i] <= load[i];
          busy[i]    <= 1'b1;
          done[i]    <= 1'b0;
        end else if (busy[i]) begin
          if (counter[i] != '0) begin
            counter[i] <= counter[i] - CW'(1);
          end else if (oneshot[i]) begin
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end else begin
            // Reload samples the current duration/prescaler, so edits land next period.
            counter[i] <= load[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_transmitter_multi_timer.sv
// Directed bench for the timer bank; expected pulses (cycle, channel mask) are queued by
// the stimulus and consumed by a monitor whenever the DUT shows any pulse.
module tb_pulse_transmitter_multi_timer;
  localparam int NUM_CH = 4;
  localparam int PSW    = 4;
  localparam int TW     = 8;
  localparam int PW     = $clog2(PSW + 1);

  logic                 clk = 1'b0;
  logic                 sys_rst;
  logic [NUM_CH-1:0]    en, oneshot;
  logic [NUM_CH*PW-1:0] prescaler;
  logic [NUM_CH*TW-1:0] duration;
  logic [NUM_CH-1:0]    pulse_out, busy, done;
  logic                 pulse_any;

  pulse_transmitter_multi_timer #(
    .NUM_CH(NUM_CH), .PRESCALER_WIDTH(PSW), .TIMER_WIDTH(TW)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .en(en), .oneshot(oneshot),
    .prescaler(prescaler), .duration(duration),
    .pulse_out(pulse_out), .busy(busy), .done(done), .pulse_any(pulse_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [NUM_CH-1:0] vec;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int c, input logic [NUM_CH-1:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input int ch, input int dur, input int pre);
    duration[ch*TW +: TW]  = dur[TW-1:0];
    prescaler[ch*PW +: PW] = pre[PW-1:0];
  endtask

  // Monitor: every cycle with a visible pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pulse_any || (|pulse_out)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: cycle %0d pulse_out=%b pulse_any=%b", cyc, pulse_out, pulse_any);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || pulse_out !== e.vec || pulse_any !== 1'b1) begin
          errors++;
          $display("FAIL pulse_match: got cycle %0d pulse_out=%b pulse_any=%b expected cycle %0d pulse_out=%b pulse_any=1",
                   cyc, pulse_out, pulse_any, e.cyc, e.vec);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    sys_rst = 1'b1; en = '0; oneshot = '0; prescaler = '0; duration = '0;
    tick(3);
    check("rst_busy", busy, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_pulse_out", pulse_out, 4'b0000);
    check("rst_pulse_any", {3'b000, pulse_any}, 4'b0000);
    sys_rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 4'b0000);

    // ch0 repeating, D=3: pulses every 4 cycles starting E0+4
    cfg(0, 3, 0); en[0] = 1'b1; e0 = cyc + 1;
    push(e0 + 4, 4'b0001); push(e0 + 8, 4'b0001); push(e0 + 12, 4'b0001);
    tick(2);
    check("rep_busy", busy, 4'b0001);
    goto_cyc(e0 + 13); en[0] = 1'b0; tick(1);
    check("rep_stop_busy", busy, 4'b0000);

    // ch3 D=0 repeating: continuous pulse from E0+1
    cfg(3, 0, 0); en[3] = 1'b1; e0 = cyc + 1;
    for (int k = 1; k <= 4; k++) push(e0 + k, 4'b1000);
    goto_cyc(e0 + 4); en[3] = 1'b0; tick(1);

    // ch3 D=0 one-shot: single pulse
    oneshot[3] = 1'b1; en[3] = 1'b1; e0 = cyc + 1;
    push(e0 + 1, 4'b1000);
    goto_cyc(e0 + 5);
    check("os0_done", done, 4'b1000);
    en[3] = 1'b0; oneshot[3] = 1'b0; tick(1);

    // ch1 one-shot, duration 2 << 2 = 8: one pulse at E0+9, held, restart on en toggle
    cfg(1, 2, 2); oneshot[1] = 1'b1; en[1] = 1'b1; e0 = cyc + 1;
    push(e0 + 9, 4'b0010);
    goto_cyc(e0 + 12);
    check("os_busy", busy, 4'b0000);
    check("os_done", done, 4'b1010);
    goto_cyc(e0 + 20);
    check("os_hold_busy", busy, 4'b0000);
    en[1] = 1'b0; tick(1);
    check("os_done_kept", done, 4'b1010);
    en[1] = 1'b1; e1 = cyc + 1;
    push(e1 + 9, 4'b0010);
    tick(1);
    check("os_restart_done", done, 4'b1000);
    check("os_restart_busy", busy, 4'b0010);
    goto_cyc(e1 + 11);
    check("os_redone", done, 4'b1010);
    en[1] = 1'b0; oneshot[1] = 1'b0; tick(1);

    // ch2 max duration, prescaler at max (4) then over max (7): same D = 4080
    for (int k = 0; k < 2; k++) begin
      cfg(2, 255, (k == 0) ? 4 : 7); en[2] = 1'b1; e0 = cyc + 1;
      push(e0 + 4081, 4'b0100);
      goto_cyc(e0 + 4000);
      check("max_busy", busy, 4'b0100);
      goto_cyc(e0 + 4082); en[2] = 1'b0; tick(1);
    end

    // ch3 D=5, duration changed to 2 mid-period: pulses E0+6, then every 3
    cfg(3, 5, 0); en[3] = 1'b1; e0 = cyc + 1;
    push(e0 + 6, 4'b1000); push(e0 + 9, 4'b1000); push(e0 + 12, 4'b1000);
    goto_cyc(e0 + 3); cfg(3, 2, 0);
    goto_cyc(e0 + 13); en[3] = 1'b0; tick(1);

    // ch0/ch1 one-shot both D=4 expire together; ch2 dropped mid-count
    cfg(0, 4, 0); cfg(1, 1, 2); cfg(2, 10, 0);
    oneshot = 4'b0011; en = 4'b0111; e0 = cyc + 1;
    push(e0 + 5, 4'b0011);
    goto_cyc(e0 + 3);
    check("dual_busy", busy, 4'b0111);
    en[2] = 1'b0; tick(1);
    check("drop_busy", busy, 4'b0011);
    goto_cyc(e0 + 7);
    check("dual_busy_end", busy, 4'b0000);
    check("dual_done", done, 4'b0011);
    en = '0; oneshot = '0; tick(1);

    // ch0 D=3, reset mid-count with en held: restart on first edge after release
    cfg(0, 3, 0); en[0] = 1'b1; e0 = cyc + 1;
    goto_cyc(e0 + 2);
    check("pre_rst_busy", busy, 4'b0001);
    sys_rst = 1'b1; tick(1);
    check("mid_rst_busy", busy, 4'b0000);
    check("mid_rst_done", done, 4'b0000);
    check("mid_rst_pulse", pulse_out, 4'b0000);
    check("mid_rst_any", {3'b000, pulse_any}, 4'b0000);
    sys_rst = 1'b0; e1 = cyc + 1;
    push(e1 + 4, 4'b0001);
    tick(1);
    check("post_rst_busy", busy, 4'b0001);
    goto_cyc(e1 + 5); en = '0; tick(3);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL pulse_missing: got none expected cycle %0d pulse_out=%b", e.cyc, e.vec);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
